pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_skid_reg_if.sv | 33 +++
 rtl/pipe_skid_reg.sv | 122 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
interface pipe_skid_reg_if #(
    parameter int unsigned W = 32
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // Producer/consumer side that surrounds the stage
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The stage itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with one-entry skid buffer, registered in_ready and synchronous flush.
// Optional stall statistics counter is compiled in with PIPE_SKID_STAT_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter bit          CLR_DATA = 1'b1
`ifdef PIPE_SKID_STAT_EN
   ,parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_STAT_EN
   ,output logic [CNT_W-1:0] stall_cnt
`endif
);

    pipe_skid_state_t r_state;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [1:0]       r_occ;
    logic [W-1:0]     r_main;
    logic [W-1:0]     r_skid;

    logic             w_push;
    logic             w_pop;

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = r_out_valid && bus.out_ready;

    // State, handshake outputs and payload all update together so outputs stay registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= OCC_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= OCC_EMPTY;
            if (CLR_DATA) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_main      <= bus.in_data;
                        r_state     <= BUSY;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_occ       <= OCC_ONE;
                    end
                end
                BUSY: begin
                    if (w_push && w_pop) begin
                        r_main <= bus.in_data;
                    end else if (w_push) begin
                        r_skid      <= bus.in_data;
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_occ       <= OCC_TWO;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_occ       <= OCC_EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry always drains behind main, preserving order
                    if (w_pop) begin
                        r_main      <= r_skid;
                        r_state     <= BUSY;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_occ       <= OCC_ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_occ       <= OCC_EMPTY;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_data  = r_main;
    assign occupancy     = r_occ;

`ifdef PIPE_SKID_STAT_EN
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where downstream holds off valid data; flush does not clear it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed table-driven bench for pipe_skid_reg plus hand sequences for reset, async reset and stall counter.
module tb_pipe_skid_reg;

    localparam int unsigned W = 32;

    typedef struct {
        logic         iv;
        logic [31:0]  din;
        logic         ordy;
        logic         fl;
        logic         ev;
        logic         eir;
        logic [1:0]   eocc;
        logic [31:0]  edat;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_STAT_EN
    logic [2:0] stall_cnt;
`endif

    int n_tests;
    int n_fail;

    vec_t vecs[$];

    pipe_skid_reg_if #(.W(W)) bus ();

    pipe_skid_reg #(
        .W        (W),
        .CLR_DATA (1'b1)
`ifdef PIPE_SKID_STAT_EN
       ,.CNT_W    (3)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STAT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic ev, input logic eir,
                            input logic [1:0] eocc, input logic [31:0] edat);
        chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({nm, " in_ready"},  32'(bus.in_ready),  32'(eir));
        chk({nm, " occupancy"}, 32'(occupancy),     32'(eocc));
        chk({nm, " out_data"},  bus.out_data,       edat);
    endtask

    task automatic add(input logic iv, input logic [31:0] din, input logic ordy, input logic fl,
                       input logic ev, input logic eir, input logic [1:0] eocc, input logic [31:0] edat);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.eir = eir; v.eocc = eocc; v.edat = edat;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [31:0] din, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = din;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held with a valid input offered: nothing may be captured
        reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        chk_outs("reset t0", 1'b0, 1'b1, 2'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_outs($sformatf("reset c%0d", c), 1'b0, 1'b1, 2'd0, 32'h0);
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming: one beat per cycle, visible one edge after acceptance
        for (int k = 1; k <= 8; k++)
            add(1'b1, 32'(k), 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'(k));
        add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h8);
        // Backpressure into the skid entry, blocked offer, then ordered drain
        add(1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA);
        add(1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA);
        add(1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA);
        add(1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB);
        add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'hB);
        // Hold in BUSY while stalled
        add(1'b1, 32'hD,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hD);
        add(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hD);
        // Flush in FULL drops the offered 0x55 and zeroes the payload
        add(1'b1, 32'hE,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hD);
        add(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
        add(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        // Flush in BUSY with a simultaneous pop and offer
        add(1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h66);
        add(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
        add(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eir, vecs[i].eocc, vecs[i].edat);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Async reset mid-cycle while FULL, then resume streaming
        drive(1'b1, 32'h31, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h32, 1'b0, 1'b0);
        step();
        chk_outs("pre-areset full", 1'b1, 1'b0, 2'd2, 32'h31);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("areset mid-cycle", 1'b0, 1'b1, 2'd0, 32'h0);
        #2;
        reset = 1'b0;
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        step();
        chk_outs("resume 11", 1'b1, 1'b1, 2'd1, 32'h11);
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        step();
        chk_outs("resume 22", 1'b1, 1'b1, 2'd1, 32'h22);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk_outs("resume drain", 1'b0, 1'b1, 2'd0, 32'h22);

`ifdef PIPE_SKID_STAT_EN
        // Stall counter saturates at 7, survives flush, clears on reset
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        step();
        chk("stall start", 32'(stall_cnt), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) step();
        chk("stall saturated", 32'(stall_cnt), 32'd7);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall after flush", 32'(stall_cnt), 32'd7);
        chk("stall flush ov", 32'(bus.out_valid), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("stall after reset", 32'(stall_cnt), 32'd0);
        #1;
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
